// File: rtl/ps2_interface.sv
// ============================================================================
// Module   : ps2_interface
// Brief    : PS/2 keyboard receiver (device-to-host). Filters the PS/2 clock,
//            deframes 11-bit frames, strobes each byte and tracks make codes.
//            Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_interface #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        ps2_clock,
  inout  wire        ps2_data,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out
);

  localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  // Without parity checking the parity bit is never stored, so the stop bit
  // lands at index 8 instead of 9.
`ifdef PS2_PARITY_CHECK_EN
  localparam int c_SHIFT_W = 10;
`else
  localparam int c_SHIFT_W = 9;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic                   r_filt_clk;
  logic [c_FILT_W-1:0]    r_filt_cnt;
  logic [3:0]             r_bit_cnt;
  logic [c_SHIFT_W-1:0]   r_shift;
  logic [c_TO_W-1:0]      r_to_cnt;
  logic                   r_break;
  logic [7:0]             r_key_data;
  logic                   r_pressed;
  logic [7:0]             r_out;
  logic                   w_fall, w_timeout, w_valid, w_shift_en;
  logic                   w_start, w_bit, w_commit;

  assign ps2_clock = 1'bz;
  assign ps2_data  = 1'bz;

  assign ps2_key_data    = r_key_data;
  assign ps2_key_pressed = r_pressed;
  assign ps2_out         = r_out;

`ifdef PS2_PARITY_CHECK_EN
  assign w_shift_en = 1'b1;
  assign w_valid    = r_shift[9] & (^r_shift[8:0]);
`else
  assign w_shift_en = (r_bit_cnt != 4'd9);
  assign w_valid    = r_shift[8];
`endif

  // Falling edge is flagged in the cycle the filter is about to flip 1->0.
  assign w_fall    = r_filt_clk & ~r_clk_s2 &
                     (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1));
  assign w_timeout = (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= ps2_clock;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_bit       = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !r_dat_s2) begin
          w_state_nxt = S_RECV;
          w_start     = 1'b1;
        end
      end
      S_RECV: begin
        if (w_fall) begin
          w_bit = 1'b1;
          if (r_bit_cnt == 4'd10) w_state_nxt = S_CHECK;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        w_commit    = w_valid;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_to_cnt   <= '0;
      r_break    <= 1'b0;
      r_key_data <= 8'h00;
      r_pressed  <= 1'b0;
      r_out      <= 8'h00;
    end else begin
      r_pressed <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= 4'd1;
      end else if (w_bit) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (w_shift_en) r_shift <= {r_dat_s2, r_shift[c_SHIFT_W-1:1]};
      end
      if (r_state != S_RECV || w_fall) r_to_cnt <= '0;
      else                              r_to_cnt <= r_to_cnt + 1'b1;
      if (w_commit) begin
        r_key_data <= r_shift[7:0];
        r_pressed  <= 1'b1;
        // The byte after a break prefix is a release code, not a make code.
        if (r_shift[7:0] == 8'hF0)      r_break <= 1'b1;
        else if (r_break)               r_break <= 1'b0;
        else if (r_shift[7:0] != 8'hE0) r_out   <= r_shift[7:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_interface.sv
// ============================================================================
// Module   : tb_ps2_interface
// Brief    : Directed self-checking bench for ps2_interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_interface;

  localparam int c_FILTER  = 8;
  localparam int c_TIMEOUT = 400;
  localparam int c_HALF    = 20;

  logic       clk;
  logic       rst;
  logic       drv_clk;
  logic       drv_dat;
  wire        ps2_clock_w;
  wire        ps2_data_w;
  logic [7:0] key_data;
  logic       key_pressed;
  logic [7:0] key_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int double_cnt = 0;
  int stop_cyc = 0;
  int p0;
  logic prev_pressed = 1'b0;

  assign ps2_clock_w = drv_clk;
  assign ps2_data_w  = drv_dat;

  ps2_interface #(.FILTER_LEN(c_FILTER), .TIMEOUT_CYCLES(c_TIMEOUT)) dut (
    .clock           (clk),
    .reset           (rst),
    .ps2_clock       (ps2_clock_w),
    .ps2_data        (ps2_data_w),
    .ps2_key_data    (key_data),
    .ps2_key_pressed (key_pressed),
    .ps2_out         (key_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_pressed) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
      if (prev_pressed) double_cnt = double_cnt + 1;
    end
    prev_pressed = key_pressed;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of a frame; data changes mid-way through clock high.
  task automatic send(input logic [7:0] b, input logic par_flip, input logic stop, input int nbits);
    logic [10:0] frame;
    frame = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      drv_dat = frame[i];
      wait_cyc(c_HALF / 2);
      drv_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(c_HALF);
      drv_clk = 1'b1;
      wait_cyc(c_HALF / 2);
    end
    drv_dat = 1'b1;
    wait_cyc(30);
  endtask

  initial begin
    rst = 1'b1;
    drv_clk = 1'b1;
    drv_dat = 1'b1;
    wait_cyc(5);
    check("rst_key_data", {24'h0, key_data}, 32'h00);
    check("rst_pressed", {31'h0, key_pressed}, 32'h0);
    check("rst_out", {24'h0, key_out}, 32'h00);
    rst = 1'b0;
    wait_cyc(20);

    p0 = pulse_cnt;
    send(8'h1C, 1'b0, 1'b1, 11);
    check("1c_pulses", pulse_cnt - p0, 1);
    check("1c_latency", pulse_cyc - stop_cyc, c_FILTER + 3);
    check("1c_key_data", {24'h0, key_data}, 32'h1C);
    check("1c_out", {24'h0, key_out}, 32'h1C);

    p0 = pulse_cnt;
    send(8'hF0, 1'b0, 1'b1, 11);
    check("f0_key_data", {24'h0, key_data}, 32'hF0);
    send(8'h1C, 1'b0, 1'b1, 11);
    check("brk_pulses", pulse_cnt - p0, 2);
    check("brk_key_data", {24'h0, key_data}, 32'h1C);
    check("brk_out", {24'h0, key_out}, 32'h1C);
    send(8'h32, 1'b0, 1'b1, 11);
    check("32_key_data", {24'h0, key_data}, 32'h32);
    check("32_out", {24'h0, key_out}, 32'h32);

    p0 = pulse_cnt;
    send(8'h1C, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
    check("par_pulses", pulse_cnt - p0, 0);
    check("par_key_data", {24'h0, key_data}, 32'h32);
    check("par_out", {24'h0, key_out}, 32'h32);
`else
    check("par_pulses", pulse_cnt - p0, 1);
    check("par_key_data", {24'h0, key_data}, 32'h1C);
    check("par_out", {24'h0, key_out}, 32'h1C);
`endif

    send(8'hE0, 1'b0, 1'b1, 11);
    check("e0_key_data", {24'h0, key_data}, 32'hE0);
`ifdef PS2_PARITY_CHECK_EN
    check("e0_out", {24'h0, key_out}, 32'h32);
`else
    check("e0_out", {24'h0, key_out}, 32'h1C);
`endif

    p0 = pulse_cnt;
    send(8'h1C, 1'b0, 1'b0, 11);
    check("stop_pulses", pulse_cnt - p0, 0);
    check("stop_key_data", {24'h0, key_data}, 32'hE0);

    // Break prefix, then a frame abandoned by timeout: the flag must survive.
    send(8'hF0, 1'b0, 1'b1, 11);
    p0 = pulse_cnt;
    send(8'h23, 1'b0, 1'b1, 5);
    wait_cyc(c_TIMEOUT + 100);
    send(8'h23, 1'b0, 1'b1, 11);
    check("to_pulses", pulse_cnt - p0, 1);
    check("to_key_data", {24'h0, key_data}, 32'h23);
`ifdef PS2_PARITY_CHECK_EN
    check("to_out", {24'h0, key_out}, 32'h32);
`else
    check("to_out", {24'h0, key_out}, 32'h1C);
`endif
    send(8'h2B, 1'b0, 1'b1, 11);
    check("2b_out", {24'h0, key_out}, 32'h2B);

    p0 = pulse_cnt;
    for (int g = 0; g < 4; g++) begin
      drv_clk = 1'b0;
      wait_cyc(3);
      drv_clk = 1'b1;
      wait_cyc(15);
    end
    check("glitch_pulses", pulse_cnt - p0, 0);
    send(8'h15, 1'b0, 1'b1, 11);
    check("glitch_next_pulses", pulse_cnt - p0, 1);
    check("glitch_next_key", {24'h0, key_data}, 32'h15);
    check("glitch_next_out", {24'h0, key_out}, 32'h15);

    send(8'h4D, 1'b0, 1'b1, 4);
    rst = 1'b1;
    wait_cyc(3);
    check("mid_rst_key_data", {24'h0, key_data}, 32'h00);
    check("mid_rst_out", {24'h0, key_out}, 32'h00);
    check("mid_rst_pressed", {31'h0, key_pressed}, 32'h0);
    rst = 1'b0;
    wait_cyc(20);
    p0 = pulse_cnt;
    send(8'h4D, 1'b0, 1'b1, 11);
    check("post_rst_pulses", pulse_cnt - p0, 1);
    check("post_rst_key", {24'h0, key_data}, 32'h4D);
    check("post_rst_out", {24'h0, key_out}, 32'h4D);

    check("no_double_pulse", double_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
